// File: rtl/rx_cp_remover.sv
// rx_cp_remover: receive-side cyclic-prefix removal and OFDM symbol framing.
// Drops CP_LEN prefix samples per symbol and forwards FFT_LEN body samples
// with sop/eop markers and the symbol index within the frame.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   frame_start        pulse (qualified by in_valid) marking CP sample 0 of symbol 0
//   in_valid           input sample strobe; gaps stall all counters
//   in_re, in_im       input sample (signed, DW bits)
//   rmsp_valid         output sample strobe (registered, one cycle latency)
//   rmsp_re, rmsp_im   forwarded body sample
//   rmsp_sop/eop       first/last body sample of a symbol
//   frame_count_out    symbol index within frame, valid with rmsp_valid
//   frame_done         pulse with the eop of the last symbol of the frame
//   sync_err           pulse when frame_start arrives mid-frame
module rx_cp_remover #(
  parameter int FFT_LEN        = 256,
  parameter int CP_LEN         = 32,
  parameter int SYMB_PER_FRAME = 100,
  parameter int DW             = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          rmsp_valid,
  output logic [DW-1:0] rmsp_re,
  output logic [DW-1:0] rmsp_im,
  output logic          rmsp_sop,
  output logic          rmsp_eop,
  output logic [6:0]    frame_count_out,
  output logic          frame_done,
  output logic          sync_err
);

  localparam int MX = (FFT_LEN > CP_LEN) ? FFT_LEN : CP_LEN;
  localparam int SW = (MX > 1) ? $clog2(MX) : 1;
  localparam logic [SW-1:0] CP_LAST   = SW'(CP_LEN - 1);
  localparam logic [SW-1:0] FFT_LAST  = SW'(FFT_LEN - 1);
  localparam logic [6:0]    SYMB_LAST = 7'(SYMB_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   samp_cnt, samp_nx;
  logic [6:0]      symb_cnt, symb_nx;
  logic            vld_nx, sop_nx, eop_nx, done_nx, serr_nx;
  logic [DW-1:0]   re_nx, im_nx;
  logic [6:0]      fc_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      samp_cnt        <= '0;
      symb_cnt        <= '0;
      rmsp_valid      <= 1'b0;
      rmsp_sop        <= 1'b0;
      rmsp_eop        <= 1'b0;
      frame_done      <= 1'b0;
      sync_err        <= 1'b0;
      rmsp_re         <= '0;
      rmsp_im         <= '0;
      frame_count_out <= '0;
    end else begin
      state           <= state_nx;
      samp_cnt        <= samp_nx;
      symb_cnt        <= symb_nx;
      rmsp_valid      <= vld_nx;
      rmsp_sop        <= sop_nx;
      rmsp_eop        <= eop_nx;
      frame_done      <= done_nx;
      sync_err        <= serr_nx;
      rmsp_re         <= re_nx;
      rmsp_im         <= im_nx;
      frame_count_out <= fc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    samp_nx  = samp_cnt;
    symb_nx  = symb_cnt;
    vld_nx   = 1'b0;
    sop_nx   = 1'b0;
    eop_nx   = 1'b0;
    done_nx  = 1'b0;
    serr_nx  = 1'b0;
    re_nx    = rmsp_re;
    im_nx    = rmsp_im;
    fc_nx    = frame_count_out;

    if (in_valid) begin
      if (frame_start) begin
        // Current sample is CP sample 0 of a new frame; anything partially
        // forwarded is abandoned without an eop.
        serr_nx = (state != IDLE);
        symb_nx = '0;
        if (CP_LEN == 1) begin
          state_nx = BODY;
          samp_nx  = '0;
        end else begin
          state_nx = CP;
          samp_nx  = SW'(1);
        end
      end else begin
        case (state)
          CP: begin
            if (samp_cnt == CP_LAST) begin
              state_nx = BODY;
              samp_nx  = '0;
            end else begin
              samp_nx = samp_cnt + SW'(1);
            end
          end
          BODY: begin
            vld_nx = 1'b1;
            re_nx  = in_re;
            im_nx  = in_im;
            sop_nx = (samp_cnt == '0);
            eop_nx = (samp_cnt == FFT_LAST);
            fc_nx  = symb_cnt;
            if (samp_cnt == FFT_LAST) begin
              samp_nx = '0;
              if (symb_cnt == SYMB_LAST) begin
                // Last symbol: stop and wait for a fresh frame_start.
                done_nx  = 1'b1;
                state_nx = IDLE;
              end else begin
                symb_nx  = symb_cnt + 7'd1;
                state_nx = CP;
              end
            end else begin
              samp_nx = samp_cnt + SW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_cp_remover.sv
module tb_rx_cp_remover;

  logic        clk = 1'b0;
  logic        rst_n;
  // main instance: FFT_LEN=8, CP_LEN=2, SYMB_PER_FRAME=3
  logic        fs, iv;
  logic [15:0] ire, iim;
  logic        ov, osop, oeop, odone, oserr;
  logic [15:0] ore, oim;
  logic [6:0]  ofc;
  // edge instance: FFT_LEN=8, CP_LEN=1, SYMB_PER_FRAME=128
  logic        fs2, iv2;
  logic [15:0] ire2, iim2;
  logic        ov2, osop2, oeop2, odone2, oserr2;
  logic [15:0] ore2, oim2;
  logic [6:0]  ofc2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rx_cp_remover #(.FFT_LEN(8), .CP_LEN(2), .SYMB_PER_FRAME(3), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(fs), .in_valid(iv),
    .in_re(ire), .in_im(iim), .rmsp_valid(ov), .rmsp_re(ore), .rmsp_im(oim),
    .rmsp_sop(osop), .rmsp_eop(oeop), .frame_count_out(ofc),
    .frame_done(odone), .sync_err(oserr));

  rx_cp_remover #(.FFT_LEN(8), .CP_LEN(1), .SYMB_PER_FRAME(128), .DW(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs2), .in_valid(iv2),
    .in_re(ire2), .in_im(iim2), .rmsp_valid(ov2), .rmsp_re(ore2), .rmsp_im(oim2),
    .rmsp_sop(osop2), .rmsp_eop(oeop2), .frame_count_out(ofc2),
    .frame_done(odone2), .sync_err(oserr2));

  // Apply one input cycle starting at a negedge; returns at the next negedge,
  // where the registered response to that sample is visible.
  task automatic drive(input logic v, input logic f, input int d);
    iv = v; fs = f; ire = 16'(d); iim = 16'(1000 + d);
    @(negedge clk);
  endtask

  task automatic drive2(input logic v, input logic f, input int d);
    iv2 = v; fs2 = f; ire2 = 16'(d); iim2 = 16'(1000 + d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ov, osop, oeop, odone, oserr} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got %b want 00000", {ov, osop, oeop, odone, oserr});
    end
    total++;
    if (ore !== 16'd0 || oim !== 16'd0 || ofc !== 7'd0) begin
      bad++; $display("FAIL reset_data got re=%0d im=%0d fc=%0d want 0", ore, oim, ofc);
    end
    total++;
    if (ov2 !== 1'b0 || ofc2 !== 7'd0) begin
      bad++; $display("FAIL reset_edge got v=%b fc=%0d want 0", ov2, ofc2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Frame 0..29: symbol k body is samples 10k+2..10k+9.
  task automatic test_frame(input string nm, input bit gapped);
    logic ev;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, i == 0, i);
      ev = (i % 10) >= 2;
      total++;
      if (ov !== ev) begin
        bad++; $display("FAIL %s valid i=%0d got %b want %b", nm, i, ov, ev);
      end
      total++;
      if (oserr !== 1'b0) begin
        bad++; $display("FAIL %s sync_err i=%0d got %b want 0", nm, i, oserr);
      end
      if (ev) begin
        total++;
        if (ore !== 16'(i) || oim !== 16'(1000 + i)) begin
          bad++; $display("FAIL %s data i=%0d got %0d/%0d want %0d/%0d", nm, i, ore, oim, i, 1000 + i);
        end
        total++;
        if (osop !== ((i % 10) == 2) || oeop !== ((i % 10) == 9)) begin
          bad++; $display("FAIL %s marks i=%0d got sop=%b eop=%b", nm, i, osop, oeop);
        end
        total++;
        if (ofc !== 7'(i / 10)) begin
          bad++; $display("FAIL %s fc i=%0d got %0d want %0d", nm, i, ofc, i / 10);
        end
        total++;
        if (odone !== (i == 29)) begin
          bad++; $display("FAIL %s done i=%0d got %b want %b", nm, i, odone, i == 29);
        end
      end
      if (gapped) begin
        // frame_start without in_valid must be ignored
        drive(1'b0, 1'b1, 0);
        total++;
        if (ov !== 1'b0 || oserr !== 1'b0) begin
          bad++; $display("FAIL %s gap i=%0d got v=%b serr=%b want 0 0", nm, i, ov, oserr);
        end
      end
    end
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic test_post_idle();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 50 + i);
      total++;
      if (ov !== 1'b0) begin
        bad++; $display("FAIL post_idle valid n=%0d got %b want 0", i, ov);
      end
    end
    drive(1'b0, 1'b0, 0);
  endtask

  // Second frame_start on sample 14 (symbol 1, body index 2).
  task automatic test_resync();
    int j;
    logic ev;
    for (int i = 0; i < 44; i++) begin
      drive(1'b1, i == 0 || i == 14, i);
      j = (i < 14) ? i : i - 14;
      ev = (j % 10) >= 2;
      total++;
      if (ov !== ev) begin
        bad++; $display("FAIL resync valid i=%0d got %b want %b", i, ov, ev);
      end
      total++;
      if (oserr !== (i == 14)) begin
        bad++; $display("FAIL resync sync_err i=%0d got %b want %b", i, oserr, i == 14);
      end
      if (ev) begin
        total++;
        if (ore !== 16'(i) || osop !== ((j % 10) == 2) || oeop !== ((j % 10) == 9)) begin
          bad++; $display("FAIL resync out i=%0d got re=%0d sop=%b eop=%b", i, ore, osop, oeop);
        end
        total++;
        if (ofc !== 7'(j / 10) || odone !== (i == 43)) begin
          bad++; $display("FAIL resync fc i=%0d got fc=%0d done=%b want %0d %b", i, ofc, odone, j / 10, i == 43);
        end
      end
    end
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 14; i++) drive(1'b1, i == 0, i);
    total++;
    if (ov !== 1'b1 || ore !== 16'd13) begin
      bad++; $display("FAIL arst_pre got v=%b re=%0d want 1 13", ov, ore);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ov, osop, oeop, odone, oserr} !== 5'b0 || ore !== 16'd0 || oim !== 16'd0 || ofc !== 7'd0) begin
      bad++; $display("FAIL arst_now got v=%b re=%0d im=%0d fc=%0d want all 0", ov, ore, oim, ofc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 14; i < 34; i++) begin
      drive(1'b1, 1'b0, i);
      total++;
      if (ov !== 1'b0) begin
        bad++; $display("FAIL arst_after valid i=%0d got %b want 0", i, ov);
      end
    end
    drive(1'b0, 1'b0, 0);
  endtask

  // CP_LEN=1, 128 symbols of 9 samples: body is i%9 in 1..8.
  task automatic test_edge_params();
    logic ev;
    for (int i = 0; i < 1152; i++) begin
      drive2(1'b1, i == 0, i);
      ev = (i % 9) != 0;
      total++;
      if (ov2 !== ev) begin
        bad++; $display("FAIL edge valid i=%0d got %b want %b", i, ov2, ev);
      end
      if (ev) begin
        total++;
        if (ore2 !== 16'(i) || osop2 !== ((i % 9) == 1) || oeop2 !== ((i % 9) == 8)) begin
          bad++; $display("FAIL edge out i=%0d got re=%0d sop=%b eop=%b", i, ore2, osop2, oeop2);
        end
        total++;
        if (ofc2 !== 7'(i / 9) || odone2 !== (i == 1151)) begin
          bad++; $display("FAIL edge fc i=%0d got fc=%0d done=%b want %0d %b", i, ofc2, odone2, i / 9, i == 1151);
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      drive2(1'b1, 1'b0, 2000 + i);
      total++;
      if (ov2 !== 1'b0 || oserr2 !== 1'b0) begin
        bad++; $display("FAIL edge wrap n=%0d got v=%b serr=%b want 0 0", i, ov2, oserr2);
      end
    end
    drive2(1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    fs = 1'b0; iv = 1'b0; ire = '0; iim = '0;
    fs2 = 1'b0; iv2 = 1'b0; ire2 = '0; iim2 = '0;
    @(negedge clk);
    test_reset();
    test_frame("nominal", 1'b0);
    test_post_idle();
    test_frame("gapped", 1'b1);
    test_resync();
    test_async_reset();
    test_frame("after_rst", 1'b0);
    test_edge_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
